// File: rtl/traffic_pkg.sv
// Shared codes and default durations for the traffic-light interval timer.
package traffic_pkg;

    localparam logic [1:0] TBASE   = 2'b00;
    localparam logic [1:0] TEXT    = 2'b01;
    localparam logic [1:0] TYEL    = 2'b10;
    localparam logic [1:0] TBASEX2 = 2'b11;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int unsigned DEF_BASE_S = 6;
    localparam int unsigned DEF_EXT_S  = 3;
    localparam int unsigned DEF_YEL_S  = 2;

endpackage

// File: rtl/traffic_timer_if.sv
// Controller <-> timer handshake: interval select, start request, expiry and status.
interface traffic_timer_if #(
    parameter int unsigned VAL_W = 4
);
    logic [1:0]     interval;
    logic           start_timer;
    logic           expired;
    logic           busy;
    logic [VAL_W:0] remaining;

    modport master (
        output interval,
        output start_timer,
        input  expired,
        input  busy,
        input  remaining
    );

    modport slave (
        input  interval,
        input  start_timer,
        output expired,
        output busy,
        output remaining
    );
endinterface

// File: rtl/tick_gen.sv
// One-second prescaler with synchronous clear; emits a single-cycle tick.
// Define TRAFFIC_TIMER_FAST_EN to shorten the tick period to 16 cycles for simulation.
module tick_gen #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
`ifdef TRAFFIC_TIMER_FAST_EN
    localparam int unsigned Period = 16;
`else
    localparam int unsigned Period = CLK_HZ;
`endif
    localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Period - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = !clr && (cnt_q == Last);

    always_ff @(posedge clk) begin
        if (!rst_n || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/traffic_timer.sv
// Programmable countdown timer for the traffic-light controller: holds tBASE/tEXT/tYEL,
// loads the selected duration on start_timer and pulses expired when it runs out.
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned VAL_W    = 4,
    parameter int unsigned DEF_BASE = DEF_BASE_S,
    parameter int unsigned DEF_EXT  = DEF_EXT_S,
    parameter int unsigned DEF_YEL  = DEF_YEL_S
) (
    input  logic             clk,
    input  logic             Reset_Sync_n,
    input  logic             Prog_Sync,
    input  logic [1:0]       Time_Param_Sel,
    input  logic [VAL_W-1:0] Time_Value,
    traffic_timer_if.slave   tif
);
    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;
    localparam logic [VAL_W:0] RemOne = (VAL_W + 1)'(1);

    logic [VAL_W-1:0] base_q, ext_q, yel_q;
    logic [VAL_W-1:0] wr_val, base_fwd, ext_fwd, yel_fwd;
    logic [VAL_W:0]   dur;
    logic [VAL_W:0]   rem_q, rem_d;
    logic             state_q, state_d;
    logic             expired_q, expired_d;
    logic             tick;

    // Zero would never expire, so it is stored as one second.
    assign wr_val = (Time_Value == '0) ? VAL_W'(1) : Time_Value;

    // A load in the same cycle as a write sees the new value.
    assign base_fwd = (Prog_Sync && Time_Param_Sel == SEL_BASE) ? wr_val : base_q;
    assign ext_fwd  = (Prog_Sync && Time_Param_Sel == SEL_EXT)  ? wr_val : ext_q;
    assign yel_fwd  = (Prog_Sync && Time_Param_Sel == SEL_YEL)  ? wr_val : yel_q;

    always_comb begin
        dur = '0;
        unique case (tif.interval)
            TBASE:   dur = {1'b0, base_fwd};
            TEXT:    dur = {1'b0, ext_fwd};
            TYEL:    dur = {1'b0, yel_fwd};
            TBASEX2: dur = {base_fwd, 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset_Sync_n) begin
            base_q <= VAL_W'(DEF_BASE);
            ext_q  <= VAL_W'(DEF_EXT);
            yel_q  <= VAL_W'(DEF_YEL);
        end else if (Prog_Sync) begin
            unique case (Time_Param_Sel)
                SEL_BASE: base_q <= wr_val;
                SEL_EXT:  ext_q  <= wr_val;
                SEL_YEL:  yel_q  <= wr_val;
                SEL_NONE: ;
            endcase
        end
    end

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (Reset_Sync_n),
        .clr   (tif.start_timer || (state_q == StIdle)),
        .tick  (tick)
    );

    // A start request takes priority over the final tick, suppressing expiry.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        expired_d = 1'b0;
        if (tif.start_timer) begin
            state_d = StRun;
            rem_d   = dur;
        end else if (state_q == StRun && tick) begin
            if (rem_q == RemOne) begin
                state_d   = StIdle;
                rem_d     = '0;
                expired_d = 1'b1;
            end else begin
                rem_d = rem_q - RemOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_Sync_n) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            expired_q <= expired_d;
        end
    end

    assign tif.expired   = expired_q;
    assign tif.busy      = (state_q == StRun);
    assign tif.remaining = rem_q;
endmodule
